// File: rtl/letter_drop_engine_if.sv
// Player/timebase inputs and slot/score outputs shared between the
// letter-drop game engine and whatever drives it (input logic, renderer).
interface letter_drop_engine_if;
    logic       start;
    logic       tick;
    logic [7:0] guess;
    logic       guess_valid;
    logic [7:0] letter1;
    logic [7:0] letter2;
    logic [7:0] letter3;
    logic [4:0] ypos1;
    logic [4:0] ypos2;
    logic [4:0] ypos3;
    logic [7:0] score;
    logic [2:0] lives;
    logic       game_over;

    modport master (
        output start, tick, guess, guess_valid,
        input  letter1, letter2, letter3, ypos1, ypos2, ypos3,
        input  score, lives, game_over
    );

    modport slave (
        input  start, tick, guess, guess_valid,
        output letter1, letter2, letter3, ypos1, ypos2, ypos3,
        output score, lives, game_over
    );
endinterface

// File: rtl/letter_drop_engine.sv
// Falling-letter game state: three slots that spawn from an LFSR, fall one
// row per step, are cleared by matching guesses and cost a life when they
// reach the bottom row.
//
// state | meaning
// IDLE  | waiting for start, slots inactive, nothing moves
// PLAY  | ticks advance letters, guesses clear them
// OVER  | lives exhausted, outputs frozen until start
module letter_drop_engine #(
    parameter int unsigned STEP_DIV    = 4,
    parameter int unsigned SPAWN_GAP   = 6,
    parameter int unsigned BOTTOM_ROW  = 22,
    parameter int unsigned START_LIVES = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic            clock_i,
    input  logic            reset_i,
    letter_drop_engine_if.slave bus
);
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW = $clog2(SPAWN_GAP + 1);
    localparam logic [4:0]    BOTTOM   = 5'(BOTTOM_ROW);
    localparam logic [4:0]    INACTIVE = 5'd31;
    localparam logic [TW-1:0] TICK_TC  = TW'(STEP_DIV - 1);
    localparam logic [SW-1:0] GAP      = SW'(SPAWN_GAP);
    localparam logic [2:0]    LIVES0   = 3'(START_LIVES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t           state_q, state_d;
    logic [2:0][7:0]  letter_q, letter_d;
    logic [2:0][4:0]  ypos_q, ypos_d;
    logic [7:0]       score_q, score_d;
    logic [2:0]       lives_q, lives_d;
    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]    spawn_cnt_q, spawn_cnt_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             game_over_q, game_over_d;

    logic             step;
    logic             hit;
    logic [1:0]       hit_idx;
    logic [1:0]       miss_cnt;
    logic             spawned;

    // Next-state: guess, then step advance, then miss, then spawn, all on one edge.
    always_comb begin
        state_d     = state_q;
        letter_d    = letter_q;
        ypos_d      = ypos_q;
        score_d     = score_q;
        lives_d     = lives_q;
        tick_cnt_d  = tick_cnt_q;
        spawn_cnt_d = spawn_cnt_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        step        = 1'b0;
        hit         = 1'b0;
        hit_idx     = 2'd0;
        miss_cnt    = 2'd0;
        spawned     = 1'b0;

        case (state_q)
            PLAY: begin
                if (bus.tick) begin
                    if (tick_cnt_q == TICK_TC) begin
                        step       = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end

                // Lowest slot wins (largest ypos); strict compare keeps lowest index on ties.
                if (bus.guess_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        if (ypos_q[i] < BOTTOM && letter_q[i] == bus.guess &&
                            (!hit || ypos_q[i] > ypos_q[hit_idx])) begin
                            hit     = 1'b1;
                            hit_idx = 2'(i);
                        end
                    end
                end
                if (hit) begin
                    ypos_d[hit_idx] = INACTIVE;
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                end

                if (step) begin
                    for (int i = 0; i < 3; i++) begin
                        if (!(hit && hit_idx == 2'(i)) && ypos_q[i] < BOTTOM) begin
                            if (ypos_q[i] + 5'd1 == BOTTOM) begin
                                ypos_d[i] = INACTIVE;
                                miss_cnt  = miss_cnt + 2'd1;
                            end else begin
                                ypos_d[i] = ypos_q[i] + 5'd1;
                            end
                        end
                    end
                end
                lives_d = (lives_q > {1'b0, miss_cnt}) ? lives_q - {1'b0, miss_cnt} : 3'd0;

                // A slot freed by a guess or miss on this edge may be refilled at once.
                if (step) begin
                    if (spawn_cnt_q >= GAP) begin
                        for (int i = 0; i < 3; i++) begin
                            if (!spawned && ypos_d[i] >= BOTTOM) begin
                                letter_d[i] = lfsr_q;
                                ypos_d[i]   = 5'd0;
                                spawned     = 1'b1;
                            end
                        end
                        spawn_cnt_d = spawned ? '0 : GAP;
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + SW'(1);
                    end
                end

                if (lives_d == 3'd0) state_d = OVER;
            end
            default: begin
                if (bus.start) begin
                    state_d     = PLAY;
                    lives_d     = LIVES0;
                    score_d     = 8'd0;
                    spawn_cnt_d = GAP;
                    tick_cnt_d  = '0;
                    ypos_d      = {3{INACTIVE}};
                end
            end
        endcase

        game_over_d = (state_d == OVER);
    end

    // State and output registers; reset returns everything to power-up values.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            letter_q    <= '0;
            ypos_q      <= {3{INACTIVE}};
            score_q     <= 8'd0;
            lives_q     <= LIVES0;
            tick_cnt_q  <= '0;
            spawn_cnt_q <= GAP;
            lfsr_q      <= LFSR_SEED;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            letter_q    <= letter_d;
            ypos_q      <= ypos_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            tick_cnt_q  <= tick_cnt_d;
            spawn_cnt_q <= spawn_cnt_d;
            lfsr_q      <= lfsr_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.letter1   = letter_q[0];
    assign bus.letter2   = letter_q[1];
    assign bus.letter3   = letter_q[2];
    assign bus.ypos1     = ypos_q[0];
    assign bus.ypos2     = ypos_q[1];
    assign bus.ypos3     = ypos_q[2];
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = game_over_q;
endmodule
